serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial ripple adder, the addition-direction counterpart of the team's subtractor blocks.
- Accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Presents sum and carry-out on an output valid/ready handshake.
- Used where area matters more than latency, e.g. accumulating small counters in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present on in1/in2.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  addend A.
- in2  input  WIDTH  addend B.
- out_valid  output  1  sum/carry valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  (in1 + in2) mod 2^WIDTH.
- carry  output  1  carry-out of the MSB addition.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state IDLE, in_ready=1, out_valid=0, sum=0, carry=0, bit counter=0, carry FF=0, operand shift registers=0.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at edge E0: capture in1/in2 into shift regs, clear carry FF, counter=0, go SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each edge: s = a[0]^b[0]^c and cout = a&b | c&(a^b) on the LSBs; shift s into the sum reg from the MSB end; shift both operand regs right; carry FF<=cout; counter++.
  - SHIFT -> DONE: on the edge where counter reaches WIDTH-1 (the WIDTH-th shift).
  - DONE: out_valid=1, sum/carry stable. On out_valid&&out_ready go IDLE.
- Latency:
  - Operands accepted at edge E0; WIDTH shift edges E1..E_WIDTH; out_valid high from edge E_WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles: E0 accept, WIDTH shift edges, one DONE handshake edge, then IDLE.
- No overlap: in_ready is low in SHIFT and DONE; in_valid there is ignored and the operands are not captured.
- Back-pressure: DONE holds sum/carry/out_valid indefinitely while out_ready=0.
- out_ready asserted outside DONE has no effect.
- Arithmetic: unsigned; wrap modulo 2^WIDTH; carry=1 iff in1+in2 >= 2^WIDTH.
- sum/carry update only during SHIFT; they keep the last result in IDLE until the next operation overwrites them.
- Reset mid-operation (SHIFT or DONE) discards the operation immediately and returns all outputs to reset values.
- WIDTH=1: a single SHIFT cycle, then DONE.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - counter width constant: clog2(WIDTH), minimum 1.
- One sub-module, full_add_bit: purely combinational a, b, cin -> s, cout, instantiated once inside the SHIFT datapath.
- Control FSM and shift registers stay in serial_adder.

Test Plan:
- Basic add: WIDTH=8, in1=8'h3C, in2=8'h05, out_ready=1 -> out_valid rises 8 edges after accept; sum=8'h41, carry=0; in_ready returns 1 one cycle after the output handshake.
- Overflow: in1=8'hFF, in2=8'h01 -> sum=8'h00, carry=1. Also in1=8'h80, in2=8'h80 -> sum=8'h00, carry=1.
- Back-pressure plus busy: hold out_ready=0 for 5 cycles after out_valid; drive in_valid with new operands throughout -> sum/carry constant, in_ready=0, new operands not captured. Release out_ready -> one handshake, back to IDLE.
- Reset mid-SHIFT: in1=8'hAA, in2=8'h55, assert rst_n=0 at the 3rd shift cycle -> outputs drop immediately to reset values. Next op 8'h01+8'h01 -> sum=8'h02, carry=0.
- Back-to-back randomized: 200 random operand pairs with in_valid held high and random out_ready -> every result equals the 9-bit reference sum; no operation dropped or duplicated.
- WIDTH=1 instance: all 4 input combinations -> {carry,sum} = 00, 01, 01, 10; out_valid one edge after accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the bit-counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must index 0..width-1; a one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_add_bit.sv
// Single-bit full adder cell; purely combinational.
module full_add_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands accepted on a valid/ready handshake, added LSB-first one bit per
// clock, result held on an output valid/ready handshake until consumed. No overlap between operations.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cy_q, cy_d, carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout;

  full_add_bit u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (cy_q),
    .s_o   (fa_s),
    .cout_o(fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cy_d      = cy_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands in sum[0].
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        carry_d          = fa_cout;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        cy_d             = fa_cout;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule
